tilt_step_scheduler: RTL and testbench

//   Turns the 4-bit tilt code (bit0 left, bit1 right, bit2 forward, bit3 back) into ball-move step pulses.

---
 rtl/tilt_step_scheduler.sv | 123 ++++++++++++
 tb/tb_tilt_step_scheduler.sv | 83 ++++++++
 2 files changed

// File: rtl/tilt_step_scheduler.sv
// tilt_step_scheduler: debounced tilt code -> ramped ball-move step pulses, X/Y share one move port
// Ports: SYSCLK clock; reset2 sync active-high reset; tilt[3:0] = {back, fwd, right, left};
//   move_ready = ball module accepts a move; x_inc/x_dec/y_inc/y_dec = one-cycle step pulses;
//   step_drop = a step came due while that axis still had one pending.
// Build option: define TILT_RAMP_EN for the slow-to-fast ramp; otherwise every step uses SLOW_PERIOD.
module tilt_step_scheduler #(
  parameter int SYSCLK_FREQUENCY_HZ = 100000000,
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int SLOW_PERIOD         = 25000000,
  parameter int FAST_PERIOD         = 5000000,
  parameter int RAMP_STEP           = 5000000,
  parameter int CNT_W               = 26
) (
  input  logic       SYSCLK,
  input  logic       reset2,
  input  logic [3:0] tilt,
  input  logic       move_ready,
  output logic       x_inc,
  output logic       x_dec,
  output logic       y_inc,
  output logic       y_dec,
  output logic       step_drop
);
  typedef enum logic [1:0] {IDLE, FIRST, RAMP, CRUISE} state_t;
  // an illegal parameter set keeps both axes from ever stepping
  localparam bit CFG_OK = SYSCLK_FREQUENCY_HZ > 0 && DEBOUNCE_CYCLES >= 1 && SLOW_PERIOD >= 2 &&
                          FAST_PERIOD >= 1 && FAST_PERIOD <= SLOW_PERIOD && RAMP_STEP >= 0;
  localparam logic [CNT_W-1:0] DB_C   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] SLOW_C = CNT_W'(SLOW_PERIOD);
  localparam logic [CNT_W-1:0] FAST_C = CNT_W'(FAST_PERIOD);
  localparam logic [CNT_W-1:0] RAMP_C = CNT_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  // per-axis direction code: bit1 = inc, bit0 = dec, 00 = none (11 folds to none)
  logic [1:0][1:0] code;
  logic [1:0][1:0] dir;
  logic [1:0]      pend;
  logic [1:0]      grant;
  logic [1:0]      drop;
  logic [3:0]      pulse_q, pulse_d;
  logic            drop_q, drop_d;
  assign code[0] = (tilt[1:0] == 2'b11) ? 2'b00 : tilt[1:0];
  assign code[1] = (tilt[3:2] == 2'b11) ? 2'b00 : tilt[3:2];
  // X always wins; Y only goes when X has nothing pending
  assign grant[0] = move_ready & pend[0];
  assign grant[1] = move_ready & pend[1] & ~pend[0];
  for (genvar a = 0; a < 2; a++) begin : g_axis
    state_t           state_q, state_d;
    logic [1:0]       raw_q, raw_d, dir_q, dir_d, acc;
    logic [CNT_W-1:0] db_q, db_d, cnt_q, cnt_d, per_q, per_d, per_nx;
    logic             pend_q, pend_d, due, chg;
    always_comb begin
      raw_d   = code[a];
      db_d    = (code[a] != raw_q) ? ONE_C : (db_q == DB_C) ? DB_C : db_q + ONE_C;
      acc     = (db_d == DB_C) ? code[a] : dir_q;
      chg     = acc != dir_q;
      due     = CFG_OK && state_q != IDLE && cnt_q == ONE_C;
`ifdef TILT_RAMP_EN
      per_nx  = (per_q - FAST_C > RAMP_C) ? per_q - RAMP_C : FAST_C;
`else
      per_nx  = SLOW_C;
`endif
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      pend_d  = pend_q;
      drop[a] = 1'b0;
      if (chg) begin
        dir_d   = acc;
        pend_d  = 1'b0;
        per_d   = SLOW_C;
        cnt_d   = SLOW_C;
        state_d = (acc == 2'b00) ? IDLE : FIRST;
      end else if (state_q != IDLE) begin
        // the reload happens at the due edge, so emit stalls never shift the schedule
        cnt_d   = due ? per_nx : cnt_q - ONE_C;
        per_d   = due ? per_nx : per_q;
        pend_d  = (pend_q & ~grant[a]) | due;
        drop[a] = due & pend_q & ~grant[a];
`ifdef TILT_RAMP_EN
        state_d = (state_q == FIRST && due) ? RAMP :
                  (state_q == RAMP && per_q == FAST_C) ? CRUISE : state_q;
`endif
      end
    end
    always_ff @(posedge SYSCLK) begin
      if (reset2) begin
        state_q <= IDLE;
        raw_q   <= 2'b00;
        dir_q   <= 2'b00;
        db_q    <= '0;
        cnt_q   <= SLOW_C;
        per_q   <= SLOW_C;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        raw_q   <= raw_d;
        dir_q   <= dir_d;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
        per_q   <= per_d;
        pend_q  <= pend_d;
      end
    end
    assign dir[a]  = dir_q;
    assign pend[a] = pend_q;
  end
  always_comb begin
    pulse_d = {grant[0] & dir[0][1], grant[0] & dir[0][0], grant[1] & dir[1][1], grant[1] & dir[1][0]};
    drop_d  = |drop;
  end
  always_ff @(posedge SYSCLK) begin
    if (reset2) begin
      pulse_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      drop_q  <= drop_d;
    end
  end
  assign {x_inc, x_dec, y_inc, y_dec} = pulse_q;
  assign step_drop = drop_q;
endmodule

// File: tb/tb_tilt_step_scheduler.sv
// tb_tilt_step_scheduler: directed-vector bench for tilt_step_scheduler
module tb_tilt_step_scheduler;
  logic       clk = 1'b0;
  logic       reset2 = 1'b1;
  logic [3:0] tilt = 4'b0000;
  logic       move_ready = 1'b1;
  logic       x_inc, x_dec, y_inc, y_dec, step_drop;
  int         vectors = 0;
  int         miscompares = 0;
  tilt_step_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_PERIOD(16),
    .FAST_PERIOD(4),
    .RAMP_STEP(4)
  ) dut (
    .SYSCLK(clk),
    .reset2(reset2),
    .tilt(tilt),
    .move_ready(move_ready),
    .x_inc(x_inc),
    .x_dec(x_dec),
    .y_inc(y_inc),
    .y_dec(y_dec),
    .step_drop(step_drop)
  );
  always #5 clk = ~clk;
  // edges (counted from the first edge that samples the new tilt) after which a held tilt pulses
  function automatic logic held_pulse(int k);
`ifdef TILT_RAMP_EN
    return k == 20 || k == 32 || k == 40 || (k >= 44 && k % 4 == 0);
`else
    return k >= 20 && (k - 20) % 16 == 0;
`endif
  endfunction
  // drive at negedge, check {x_inc,x_dec,y_inc,y_dec,step_drop} 1 time unit after the next posedge
  task automatic cyc(input logic [3:0] t, input logic r, input logic rd, input logic [4:0] e, input string tag);
    logic [4:0] obs;
    @(negedge clk);
    tilt = t;
    reset2 = r;
    move_ready = rd;
    @(posedge clk);
    #1;
    obs = {x_inc, x_dec, y_inc, y_dec, step_drop};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, e);
    end
  endtask
  task automatic do_reset();
    cyc(4'b0000, 1'b1, 1'b1, 5'b00000, "reset0");
    cyc(4'b0000, 1'b1, 1'b1, 5'b00000, "reset1");
  endtask
  initial begin
    do_reset();
    for (int k = 0; k <= 70; k++)
      cyc(4'b0010, 1'b0, 1'b1, {held_pulse(k), 4'b0000}, $sformatf("held_right k=%0d", k));
    do_reset();
    for (int k = 0; k <= 30; k++)
      cyc((k < 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b1, 5'b00000, $sformatf("glitch_left k=%0d", k));
    do_reset();
    for (int k = 0; k <= 60; k++)
      cyc(4'b0101, 1'b0, 1'b1, {1'b0, held_pulse(k), 1'b0, held_pulse(k - 1), 1'b0},
          $sformatf("tie_left_fwd k=%0d", k));
    do_reset();
    for (int k = 0; k <= 45; k++) begin
`ifdef TILT_RAMP_EN
      cyc(4'b0010, 1'b0, !(k >= 18 && k <= 36), {k == 37 || k == 40 || k == 44, 3'b000, k == 31},
          $sformatf("stall_drop k=%0d", k));
`else
      cyc(4'b0010, 1'b0, !(k >= 18 && k <= 36), {k == 37, 3'b000, k == 35},
          $sformatf("stall_drop k=%0d", k));
`endif
    end
    do_reset();
    for (int k = 0; k <= 67; k++)
      cyc((k < 25) ? 4'b0010 : 4'b0001, k == 45, 1'b1, {k == 20, k == 66, 3'b000},
          $sformatf("reverse_reset k=%0d", k));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
